// File: rtl/sdram_ch0_arbiter.sv
// sdram_ch0_arbiter
// Shares SDRAM channel 0 between three clk_sys requesters (p0 ioctl loader,
// p1 screen/char-map engine, p2 font fetch) with fixed priority p0 > p1 > p2.
// Each access runs strobe -> settle -> wait-not-busy -> ack.
// Optional feature macro: REFRESH_SCHED_EN
//   defined   : interval timer, pending flag, REFRESH state, refresh_overrun.
//   undefined : refresh is raised combinationally whenever the arbiter is idle
//               with no requests; refresh_overrun is tied low.
//
// Handshake: req[k] is a level request. While it is high, wr/addr/din of port k
// must stay stable. ack[k] is a one-cycle pulse that marks completion. A req
// bit that is still high in the cycle after its ack is treated as a new
// request. If req drops before ack, the access still completes and acks.
module sdram_ch0_arbiter #(
  parameter int N_SETTLE         = 2,
  parameter int REFRESH_INTERVAL = 1024,
  parameter int REFRESH_CYCLES   = 8
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        init_done,
  input  logic [2:0]  req,
  input  logic [2:0]  wr,
  input  logic [74:0] addr,
  input  logic [23:0] din,
  output logic [2:0]  ack,
  output logic [7:0]  rdata,
  output logic [24:0] ch0_addr,
  output logic [7:0]  ch0_din,
  output logic        ch0_rd,
  output logic        ch0_wr,
  input  logic [7:0]  ch0_dout,
  input  logic        ch0_busy,
  output logic        refresh,
  output logic        refresh_overrun,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_REFRESH = 3'd5;

  localparam logic [3:0] SETTLE_LAST = 4'(N_SETTLE - 1);

  // Out-of-range parameters leave the arbiter inert instead of mis-sequencing.
  localparam logic CFG_OK = (N_SETTLE >= 1) && (N_SETTLE <= 15) &&
                            (REFRESH_CYCLES >= 1) && (REFRESH_CYCLES <= 15) &&
                            (REFRESH_INTERVAL >= 2) && (REFRESH_INTERVAL <= 65536);

  logic [2:0]  r_state;
  logic [3:0]  r_cnt;
  logic [1:0]  r_grant;
  logic        r_is_wr;
  logic [2:0]  r_ack;
  logic [7:0]  r_rdata;
  logic [24:0] r_ch0_addr;
  logic [7:0]  r_ch0_din;
  logic        r_ch0_rd;
  logic        r_ch0_wr;

  logic [1:0]  w_sel;
  logic [24:0] w_sel_addr;
  logic [7:0]  w_sel_din;
  logic        w_sel_wr;
  logic        w_any_req;
  logic        w_refresh_pending;

  // Fixed-priority pick among the requesting ports and mux of its fields.
  always_comb begin
    w_sel      = 2'd0;
    w_any_req  = |req;
    if (req[0])      w_sel = 2'd0;
    else if (req[1]) w_sel = 2'd1;
    else if (req[2]) w_sel = 2'd2;
    w_sel_addr = addr[24:0];
    w_sel_din  = din[7:0];
    w_sel_wr   = wr[0];
    case (w_sel)
      2'd1: begin
        w_sel_addr = addr[49:25];
        w_sel_din  = din[15:8];
        w_sel_wr   = wr[1];
      end
      2'd2: begin
        w_sel_addr = addr[74:50];
        w_sel_din  = din[23:16];
        w_sel_wr   = wr[2];
      end
      default: ;
    endcase
  end

`ifdef REFRESH_SCHED_EN
  localparam logic [15:0] TIMER_LAST = 16'(REFRESH_INTERVAL - 1);
  localparam logic [3:0]  REF_LAST   = 4'(REFRESH_CYCLES - 1);

  logic [15:0] r_timer;
  logic        r_pending;
  logic        r_overrun;
  logic        r_refresh;
  logic        w_ref_done;

  assign w_ref_done        = (r_state == S_REFRESH) && (r_cnt == REF_LAST);
  assign w_refresh_pending = r_pending;

  // Free-running refresh interval timer; a wrap raises pending, a wrap onto an
  // unserved pending sets the sticky overrun flag.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_timer   <= '0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (r_timer == TIMER_LAST) begin
        r_timer   <= '0;
        r_pending <= 1'b1;
        if (r_pending && !w_ref_done) r_overrun <= 1'b1;
      end else begin
        r_timer <= r_timer + 16'd1;
        if (w_ref_done) r_pending <= 1'b0;
      end
    end
  end

  assign refresh         = r_refresh;
  assign refresh_overrun = r_overrun;
`else
  assign w_refresh_pending = 1'b0;
  assign refresh           = (r_state == S_IDLE) && init_done && (req == 3'b000);
  assign refresh_overrun   = 1'b0;
`endif

  // Access sequencer: arbitrate in IDLE, then strobe, settle, wait, ack.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_grant    <= '0;
      r_is_wr    <= 1'b0;
      r_ack      <= '0;
      r_rdata    <= '0;
      r_ch0_addr <= '0;
      r_ch0_din  <= '0;
      r_ch0_rd   <= 1'b0;
      r_ch0_wr   <= 1'b0;
`ifdef REFRESH_SCHED_EN
      r_refresh  <= 1'b0;
`endif
    end else begin
      r_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (init_done && CFG_OK) begin
            if (w_refresh_pending) begin
`ifdef REFRESH_SCHED_EN
              r_state   <= S_REFRESH;
              r_cnt     <= '0;
              r_refresh <= 1'b1;
`endif
            end else if (w_any_req) begin
              r_state    <= S_ISSUE;
              r_grant    <= w_sel;
              r_is_wr    <= w_sel_wr;
              r_ch0_addr <= w_sel_addr;
              r_ch0_din  <= w_sel_din;
              r_ch0_wr   <= w_sel_wr;
              r_ch0_rd   <= !w_sel_wr;
            end
          end
        end
        S_ISSUE: begin
          r_ch0_rd <= 1'b0;
          r_ch0_wr <= 1'b0;
          r_cnt    <= '0;
          r_state  <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_cnt == SETTLE_LAST) r_state <= S_WAIT;
          else                      r_cnt   <= r_cnt + 4'd1;
        end
        S_WAIT: begin
          if (!ch0_busy) begin
            if (!r_is_wr) r_rdata <= ch0_dout;
            r_ack   <= 3'b001 << r_grant;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
`ifdef REFRESH_SCHED_EN
        S_REFRESH: begin
          if (r_cnt == REF_LAST) begin
            r_refresh <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack       = r_ack;
  assign rdata     = r_rdata;
  assign ch0_addr  = r_ch0_addr;
  assign ch0_din   = r_ch0_din;
  assign ch0_rd    = r_ch0_rd;
  assign ch0_wr    = r_ch0_wr;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_sdram_ch0_arbiter.sv
// tb_sdram_ch0_arbiter
// Bench for sdram_ch0_arbiter. Expected {ack, rdata} pairs are queued when an
// access is driven and popped by a monitor when an ack pulse appears.
// Build with +define+REFRESH_SCHED_EN to exercise the scheduled-refresh variant.
module tb_sdram_ch0_arbiter;

`ifdef REFRESH_SCHED_EN
  localparam int TB_INTERVAL = 16;
`else
  localparam int TB_INTERVAL = 1024;
`endif

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd3;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        init_done;
  logic [2:0]  req;
  logic [2:0]  wr;
  logic [74:0] addr;
  logic [23:0] din;
  logic [2:0]  ack;
  logic [7:0]  rdata;
  logic [24:0] ch0_addr;
  logic [7:0]  ch0_din;
  logic        ch0_rd;
  logic        ch0_wr;
  logic [7:0]  ch0_dout;
  logic        ch0_busy;
  logic        refresh;
  logic        refresh_overrun;
  logic [2:0]  dbg_state;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic        sb_en;
  logic [10:0] exp_q[$];
  logic [10:0] sb_e;
  logic [7:0]  model_rdata;

  sdram_ch0_arbiter #(
    .N_SETTLE(2),
    .REFRESH_INTERVAL(TB_INTERVAL),
    .REFRESH_CYCLES(8)
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .init_done(init_done),
    .req(req),
    .wr(wr),
    .addr(addr),
    .din(din),
    .ack(ack),
    .rdata(rdata),
    .ch0_addr(ch0_addr),
    .ch0_din(ch0_din),
    .ch0_rd(ch0_rd),
    .ch0_wr(ch0_wr),
    .ch0_dout(ch0_dout),
    .ch0_busy(ch0_busy),
    .refresh(refresh),
    .refresh_overrun(refresh_overrun),
    .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: every ack pulse must match the oldest queued expectation
  always @(negedge clk_sys) begin
    if (sb_en && ack !== 3'b000) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_ack", {21'd0, ack, rdata}, 32'd0);
      end else begin
        sb_e = exp_q.pop_front();
        check("sb_ack_rdata", {21'd0, ack, rdata}, {21'd0, sb_e});
      end
    end
  end

  task automatic do_reset();
    @(negedge clk_sys);
    reset = 1'b1;
    req   = 3'b000;
    repeat (3) @(negedge clk_sys);
    reset       = 1'b0;
    model_rdata = 8'h00;
  endtask

  task automatic set_port(input int k, input logic w, input logic [24:0] a, input logic [7:0] d);
    wr[k]          = w;
    addr[25*k +: 25] = a;
    din[8*k +: 8]  = d;
  endtask

  // Waits (bounded) for an ack on any port in mask; n = negedges waited
  task automatic wait_ack(input logic [2:0] mask, output int n);
    n = 0;
    while (n < 300) begin
      @(negedge clk_sys);
      n++;
      if ((ack & mask) != 3'b000) begin
        req = req & ~ack;
        break;
      end
    end
  endtask

  int n;
  int bad;
  int t_ack[3];
  int k_seen;
  int run_len, bursts, badlen, overlap, p2_acks;
  logic got_ack;

  initial begin
    reset     = 1'b1;
    init_done = 1'b0;
    req       = 3'b000;
    wr        = 3'b000;
    addr      = '0;
    din       = '0;
    ch0_dout  = 8'h00;
    ch0_busy  = 1'b0;
    sb_en     = 1'b1;
    model_rdata = 8'h00;

    // ---- init_done low blocks all grants ----
    do_reset();
    req = 3'b111;
    bad = 0;
    repeat (100) begin
      @(negedge clk_sys);
      if (ch0_rd || ch0_wr || ack != 3'b000 || refresh) bad++;
    end
    check("noinit_activity", bad, 0);
    check("noinit_ack", ack, 3'b000);
    check("noinit_rdata", rdata, 8'h00);
    check("noinit_addr", ch0_addr, 25'h0);
    check("noinit_din", ch0_din, 8'h00);
    check("noinit_state", dbg_state, ST_IDLE);
`ifdef REFRESH_SCHED_EN
    check("noinit_overrun", refresh_overrun, 1'b1);
`else
    check("noinit_overrun", refresh_overrun, 1'b0);
`endif

`ifdef REFRESH_SCHED_EN
    // ---- scheduled refresh with p2 hogging the channel ----
    sb_en = 1'b0;
    do_reset();
    init_done = 1'b1;
    ch0_dout  = 8'h3C;
    set_port(2, 1'b0, 25'h1000000, 8'h00);
    req = 3'b100;
    run_len = 0; bursts = 0; badlen = 0; overlap = 0; p2_acks = 0;
    repeat (160) begin
      @(negedge clk_sys);
      if (refresh && (ch0_rd || ch0_wr)) overlap++;
      if (ack == 3'b100) p2_acks++;
      if (refresh) run_len++;
      else if (run_len > 0) begin
        if (run_len != 8) badlen++;
        bursts++;
        run_len = 0;
      end
    end
    check("sched_overlap", overlap, 0);
    check("sched_burst_len", badlen, 0);
    check("sched_burst_count", (bursts >= 8 && bursts <= 10) ? 1 : 0, 1);
    check("sched_p2_progress", (p2_acks > 0) ? 1 : 0, 1);
    check("sched_no_overrun", refresh_overrun, 1'b0);
    ch0_busy = 1'b1;
    repeat (40) @(negedge clk_sys);
    ch0_busy = 1'b0;
    repeat (20) @(negedge clk_sys);
    check("sched_overrun", refresh_overrun, 1'b1);
    req = 3'b000;
`else
    // ---- idle refresh ----
    do_reset();
    init_done = 1'b1;
    @(negedge clk_sys);
    check("idle_refresh_on", refresh, 1'b1);

    // ---- p1 read, latency and strobe timing ----
    ch0_busy = 1'b0;
    ch0_dout = 8'h41;
    set_port(1, 1'b0, 25'h0002005, 8'h00);
    model_rdata = 8'h41;
    exp_q.push_back({3'b010, model_rdata});
    req = 3'b010;
    n = 0;
    got_ack = 1'b0;
    while (!got_ack && n < 100) begin
      @(negedge clk_sys);
      n++;
      if (n == 1) begin
        check("rd_strobe", ch0_rd, 1'b1);
        check("rd_addr", ch0_addr, 25'h0002005);
        check("rd_refresh_low", refresh, 1'b0);
      end
      if (n == 2) check("rd_strobe_low", ch0_rd, 1'b0);
      if (ack != 3'b000) begin
        got_ack = 1'b1;
        req = 3'b000;
      end
    end
    check("rd_latency", n, 5);

    // ---- all three ports held: order p0, p1, p2, 6 cycles apart ----
    @(negedge clk_sys);
    ch0_dout = 8'h5A;
    set_port(0, 1'b0, 25'h0000010, 8'h00);
    set_port(1, 1'b0, 25'h0000020, 8'h00);
    set_port(2, 1'b0, 25'h0000030, 8'h00);
    model_rdata = 8'h5A;
    exp_q.push_back({3'b001, model_rdata});
    exp_q.push_back({3'b010, model_rdata});
    exp_q.push_back({3'b100, model_rdata});
    req = 3'b111;
    n = 0;
    k_seen = 0;
    while (req != 3'b000 && n < 200) begin
      @(negedge clk_sys);
      n++;
      if (ack != 3'b000) begin
        check("arb_onehot", $countones(ack), 1);
        if (k_seen < 3) t_ack[k_seen] = cyc;
        k_seen++;
        req = req & ~ack;
      end
    end
    check("arb_ack_count", k_seen, 3);
    check("arb_gap01", t_ack[1] - t_ack[0], 6);
    check("arb_gap12", t_ack[2] - t_ack[1], 6);

    // ---- p0 write with long busy ----
    @(negedge clk_sys);
    ch0_busy = 1'b1;
    set_port(0, 1'b1, 25'h1ABCDEF, 8'hA5);
    exp_q.push_back({3'b001, model_rdata});
    req = 3'b001;
    n = 0;
    bad = 0;
    got_ack = 1'b0;
    while (!got_ack && n < 100) begin
      @(negedge clk_sys);
      n++;
      if (n == 1) begin
        check("wr_strobe", ch0_wr, 1'b1);
        check("wr_din", ch0_din, 8'hA5);
      end else if (n <= 21) begin
        if (ch0_din != 8'hA5 || ch0_wr || ch0_rd) bad++;
      end
      if (n == 10) check("wr_wait_state", dbg_state, ST_WAIT);
      if (n == 21) ch0_busy = 1'b0;
      if (ack != 3'b000) begin
        got_ack = 1'b1;
        req = 3'b000;
        check("wr_din_at_ack", ch0_din, 8'hA5);
      end
    end
    check("wr_din_stable", bad, 0);
    check("wr_latency", n, 22);

    // ---- reset during WAIT of a p1 read ----
    @(negedge clk_sys);
    ch0_busy = 1'b1;
    ch0_dout = 8'h77;
    set_port(1, 1'b0, 25'h0000444, 8'h00);
    req = 3'b010;
    n = 0;
    while (dbg_state != ST_WAIT && n < 50) begin
      @(negedge clk_sys);
      n++;
    end
    check("rst_reached_wait", dbg_state, ST_WAIT);
    reset = 1'b1;
    @(negedge clk_sys);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_ack", ack, 3'b000);
    check("rst_strobes", {ch0_rd, ch0_wr}, 2'b00);
    check("rst_rdata", rdata, 8'h00);
    reset       = 1'b0;
    ch0_busy    = 1'b0;
    model_rdata = 8'h77;
    exp_q.push_back({3'b010, model_rdata});
    wait_ack(3'b010, n);
    check("rst_recover_latency", n, 5);
    req = 3'b000;
`endif

    repeat (10) @(negedge clk_sys);
    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Run-time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
